// File: rtl/uart_bus_pkg.sv
// Shared constants and FSM state type for the UART register-bus sequencer.
package uart_bus_pkg;

  localparam logic [3:0] UART_ADDR_TX_DATA = 4'h0;
  localparam logic [3:0] UART_ADDR_RX_DATA = 4'h1;
  localparam logic [3:0] UART_ADDR_STATUS  = 4'h2;

  localparam int UART_BIT_TX_FULL  = 0;
  localparam int UART_BIT_RX_EMPTY = 1;

  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STAT   = 3'd1,
    DECIDE = 3'd2,
    TX_WR  = 3'd3,
    RX_RD  = 3'd4,
    GAP    = 3'd5
  } bus_state_e;

  function automatic logic is_access(bus_state_e s);
    return (s == STAT) || (s == TX_WR) || (s == RX_RD);
  endfunction

endpackage

// File: rtl/uart_bus_strobe_timer.sv
// Loadable down-counter: nonzero count marks a strobe (or gap) cycle, count==1
// is the last one, count==0 is the recovery/idle point.
module uart_bus_strobe_timer
  import uart_bus_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         last_o,
  output logic         done_o,
  output logic         nxt_active_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last_o       = (cnt_q == W'(1));
  assign done_o       = (cnt_q == '0);
  // Lets the owner register its strobes from next-cycle timer state.
  assign nxt_active_o = (cnt_d != '0);

endmodule

// File: rtl/uart_bus_sequencer.sv
// Bus master for the UART core register bus: polls status, pushes queued TX
// bytes into the TX FIFO and pulls RX bytes into a valid/ready stream.
module uart_bus_sequencer
  import uart_bus_pkg::*;
#(
  parameter logic [3:0] ADDR_TX_DATA  = UART_ADDR_TX_DATA,
  parameter logic [3:0] ADDR_RX_DATA  = UART_ADDR_RX_DATA,
  parameter logic [3:0] ADDR_STATUS   = UART_ADDR_STATUS,
  parameter int         BIT_TX_FULL   = UART_BIT_TX_FULL,
  parameter int         BIT_RX_EMPTY  = UART_BIT_RX_EMPTY,
  parameter int         STROBE_CYCLES = 2,
  parameter int         POLL_GAP      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic [3:0] AddrBus_o,
  output logic       n_ChipSelect_o,
  output logic       n_rd_o,
  output logic       n_we_o,
  output logic [7:0] DataBus_o,
  input  logic [7:0] DataBus_i,
  output logic       busy_o
);

  bus_state_e state_q, state_d;

  logic             hold_full_q, hold_full_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             tx_full_q, tx_full_d;
  logic             rx_empty_q, rx_empty_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [3:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             ncs_q, ncs_d;
  logic             nrd_q, nrd_d;
  logic             nwe_q, nwe_d;
  logic             busy_q, busy_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_last, tmr_done, tmr_nxt;
  logic             strobe_nxt;

  uart_bus_strobe_timer #(.W(TMR_W)) u_tmr (
    .clk          (clk),
    .rst          (rst),
    .load_i       (tmr_load),
    .load_val_i   (tmr_val),
    .last_o       (tmr_last),
    .done_o       (tmr_done),
    .nxt_active_o (tmr_nxt)
  );

  // Next state and timer load.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = TMR_W'(STROBE_CYCLES);
    case (state_q)
      IDLE:   if (hold_full_q || !rx_valid_q) state_d = STAT;
      STAT:   if (tmr_last) state_d = DECIDE;
      DECIDE: begin
        // RX first so the core's RX FIFO drains before it can overflow.
        if (!rx_empty_q && !rx_valid_q)      state_d = RX_RD;
        else if (hold_full_q && !tx_full_q)  state_d = TX_WR;
        else if (POLL_GAP > 0)               state_d = GAP;
        else                                 state_d = IDLE;
      end
      TX_WR, RX_RD: if (tmr_done) state_d = IDLE;
      GAP:    if (tmr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q && state_d != IDLE && state_d != DECIDE) begin
      tmr_load = 1'b1;
      if (state_d == GAP) tmr_val = TMR_W'(POLL_GAP);
    end
  end

  // Holding register, status capture and RX stream.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    tx_full_d   = tx_full_q;
    rx_empty_d  = rx_empty_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    if (tx_valid_i && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data_i;
    end else if (state_q == TX_WR && tmr_last) begin
      hold_full_d = 1'b0;
    end
    if (state_q == STAT && tmr_last) begin
      tx_full_d  = DataBus_i[BIT_TX_FULL];
      rx_empty_d = DataBus_i[BIT_RX_EMPTY];
    end
    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (state_q == RX_RD && tmr_last) begin
      rx_valid_d = 1'b1;
      rx_data_d  = DataBus_i;
    end
  end

  // Bus pins are registered from next-cycle state.
  always_comb begin
    addr_d = addr_q;
    case (state_d)
      STAT:    addr_d = ADDR_STATUS;
      TX_WR:   addr_d = ADDR_TX_DATA;
      RX_RD:   addr_d = ADDR_RX_DATA;
      default: ;
    endcase
    strobe_nxt = is_access(state_d) && tmr_nxt;
    ncs_d  = !strobe_nxt;
    nrd_d  = !(strobe_nxt && state_d != TX_WR);
    nwe_d  = !(strobe_nxt && state_d == TX_WR);
    data_d = (state_d == TX_WR) ? hold_data_q : 8'h00;
    busy_d = !(state_d == IDLE || state_d == GAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= 8'h00;
      tx_full_q   <= 1'b0;
      rx_empty_q  <= 1'b1;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      addr_q      <= 4'h0;
      data_q      <= 8'h00;
      ncs_q       <= 1'b1;
      nrd_q       <= 1'b1;
      nwe_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      tx_full_q   <= tx_full_d;
      rx_empty_q  <= rx_empty_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ncs_q       <= ncs_d;
      nrd_q       <= nrd_d;
      nwe_q       <= nwe_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_ready_o     = !hold_full_q;
  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign AddrBus_o      = addr_q;
  assign n_ChipSelect_o = ncs_q;
  assign n_rd_o         = nrd_q;
  assign n_we_o         = nwe_q;
  assign DataBus_o      = data_q;
  assign busy_o         = busy_q;

endmodule
